// File: rtl/branch_ctrl.sv
// Branch resolution and 2-bit BHT prediction controller for the OTTER pipeline.
// Resolves EX-stage branches, redirects on mispredict, then inserts one recovery bubble.
module branch_ctrl #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_func3,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic             ex_pred_taken,
  input  logic             br_eq,
  input  logic             br_lt,
  input  logic             br_ltu,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             illegal_br,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t           state, state_nxt;
  logic [1:0]       bht [DEPTH];
  logic [IDX_W-1:0] upd_idx;
  logic             is_br, act, legal, taken, mispredict;

  assign pred_taken = bht[if_pc[IDX_W+1:2]][1];
  assign upd_idx    = ex_pc[IDX_W+1:2];
  assign is_br      = (ex_opcode == 7'b1100011);
  // The slot in EX during RECOVER is the flushed wrong-path instruction.
  assign act        = ex_valid & ~ex_stall & is_br & (state == IDLE);

  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (ex_func3)
      3'b000:  taken = br_eq;
      3'b001:  taken = ~br_eq;
      3'b100:  taken = br_lt;
      3'b101:  taken = ~br_lt;
      3'b110:  taken = br_ltu;
      3'b111:  taken = ~br_ltu;
      default: legal = 1'b0;
    endcase
  end

  assign illegal_br  = act & ~legal;
  assign mispredict  = act & legal & (taken != ex_pred_taken);
  assign redirect    = mispredict;
  assign flush       = mispredict;
  assign redirect_pc = taken ? ex_pc + ex_imm : ex_pc + 32'd4;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mispredict) state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) bht[i] <= 2'b01;
    end else if (act & legal) begin
      if (taken) begin
        if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
      end else begin
        if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if ((act & legal) && (branch_cnt != '1)) branch_cnt <= branch_cnt + CNT_ONE;
      if (mispredict && (mispred_cnt != '1))   mispred_cnt <= mispred_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: driver pushes reference-model expectations, monitor pops and compares.
module tb_branch_ctrl;

  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   if_pc;
  logic          pred_taken;
  logic          ex_valid, ex_stall, ex_pred_taken;
  logic [6:0]    ex_opcode;
  logic [2:0]    ex_func3;
  logic [31:0]   ex_pc, ex_imm;
  logic          br_eq, br_lt, br_ltu;
  logic          redirect, flush, illegal_br;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] branch_cnt, mispred_cnt;

  branch_ctrl #(.IDX_W(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_opcode(ex_opcode),
    .ex_func3(ex_func3), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_pred_taken(ex_pred_taken), .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .illegal_br(illegal_br), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ill;
    logic        pred;
    int          bcnt;
    int          mcnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: counters as integers 0..3, plain recovery flag and counts.
  int bht_m [16];
  bit rec_m;
  int bcnt_m, mcnt_m;

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit s, input logic [6:0] op,
                      input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                      input bit pred, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ipc);
    exp_t e;
    bit   leg, tk, actm, mis;
    int   ix;
    @(negedge clk);
    rst = r; ex_valid = v; ex_stall = s; ex_opcode = op; ex_func3 = f3;
    ex_pc = pc; ex_imm = imm; ex_pred_taken = pred; if_pc = ipc;
    br_eq = (a == b); br_lt = ($signed(a) < $signed(b)); br_ltu = (a < b);
    if (r) begin
      foreach (bht_m[i]) bht_m[i] = 1;
      rec_m = 0; bcnt_m = 0; mcnt_m = 0;
    end
    leg  = (f3 != 3'd2) && (f3 != 3'd3);
    tk   = ref_taken(f3, a, b);
    actm = v && !s && (op == OP_BR) && !rec_m;
    mis  = actm && leg && (tk != pred);
    e.redir = mis;
    e.rpc   = tk ? pc + imm : pc + 32'd4;
    e.ill   = actm && !leg;
    e.pred  = bht_m[ipc[5:2]] >= 2;
    e.bcnt  = bcnt_m;
    e.mcnt  = mcnt_m;
    sb.push_back(e);
    if (!r) begin
      if (actm && leg) begin
        ix = int'(pc[5:2]);
        bht_m[ix] = tk ? ((bht_m[ix] < 3) ? bht_m[ix] + 1 : 3)
                       : ((bht_m[ix] > 0) ? bht_m[ix] - 1 : 0);
        if (bcnt_m < CMAX) bcnt_m++;
      end
      if (mis && mcnt_m < CMAX) mcnt_m++;
      rec_m = mis;
    end
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                    input bit pred, input logic [31:0] a, input logic [31:0] b, input bit s);
    step(0, 1, s, OP_BR, f3, pc, imm, pred, a, b, pc);
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(0, 0, 0, 7'h13, 3'd0, 32'h0, 32'h0, 0, 0, 0, ipc);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("redirect",    {31'd0, redirect},   {31'd0, e.redir});
        chk("flush",       {31'd0, flush},      {31'd0, e.redir});
        chk("redirect_pc", redirect_pc,         e.rpc);
        chk("illegal_br",  {31'd0, illegal_br}, {31'd0, e.ill});
        chk("pred_taken",  {31'd0, pred_taken}, {31'd0, e.pred});
        chk("branch_cnt",  32'(branch_cnt),     32'(e.bcnt));
        chk("mispred_cnt", 32'(mispred_cnt),    32'(e.mcnt));
      end
    end
  end

  initial begin : driver
    logic [2:0] f3;
    logic [31:0] pc, a, b;
    bit pred;
    rst = 1'b1; ex_valid = 0; ex_stall = 0; ex_opcode = '0; ex_func3 = '0;
    ex_pc = '0; ex_imm = '0; ex_pred_taken = 0; if_pc = '0;
    br_eq = 0; br_lt = 0; br_ltu = 0;

    step(1, 0, 0, 7'h13, 0, 0, 0, 0, 0, 0, 32'h100);
    idle(32'h100);
    // Taken BEQ predicted not-taken, then a BEQ during the recovery bubble.
    br(3'd0, 32'h100, 32'h20, 0, 32'd5, 32'd5, 0);
    br(3'd0, 32'h100, 32'h20, 0, 32'd5, 32'd5, 0);
    idle(32'h100);
    repeat (3) br(3'd0, 32'h100, 32'h20, 1, 32'd9, 32'd9, 0);
    br(3'd0, 32'h100, 32'h20, 1, 32'd1, 32'd2, 0);
    idle(32'h100);
    // BGEU / BGE with rs1=0xFFFFFFFF, rs2=1.
    br(3'd7, 32'h200, 32'h40, 0, 32'hFFFF_FFFF, 32'd1, 0);
    idle(32'h200);
    br(3'd5, 32'h200, 32'h40, 0, 32'hFFFF_FFFF, 32'd1, 0);
    // Illegal func3, then a stalled mispredicting BNE released next cycle.
    br(3'd2, 32'h300, 32'h8, 0, 32'd3, 32'd3, 0);
    br(3'd3, 32'h300, 32'h8, 1, 32'd3, 32'd4, 0);
    br(3'd1, 32'h304, 32'hFFFF_FFF0, 0, 32'd3, 32'd4, 1);
    br(3'd1, 32'h304, 32'hFFFF_FFF0, 0, 32'd3, 32'd4, 0);
    idle(32'h304);
    // Drive both statistics counters into saturation.
    for (int i = 0; i < CMAX + 5; i++) begin
      br(3'd0, 32'h400 + 32'(i * 4), 32'h40, 0, 32'd7, 32'd7, 0);
      idle(32'h400);
    end
    // Reset counters with a short step so random traffic can exercise counts again.
    step(1, 0, 0, 7'h13, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 600; i++) begin
      f3 = 3'($urandom_range(0, 7));
      pc = {$urandom} & 32'h0000_00FC;
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b  = ($urandom_range(0, 1) == 0) ? a : 32'($urandom_range(0, 3));
      pred = ($urandom_range(0, 2) != 0) ? (bht_m[pc[5:2]] >= 2) : 1'($urandom);
      step(0, ($urandom_range(0, 5) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) != 0) ? OP_BR : 7'h33, f3, pc,
           {$urandom} & 32'hFFFF_FFFE, pred, a, b, {$urandom} & 32'h0000_00FC);
    end
    // Reset asserted while in the recovery bubble.
    br(3'd0, 32'h500, 32'h10, 0, 32'd1, 32'd1, 0);
    step(1, 0, 0, 7'h13, 0, 0, 0, 0, 0, 0, 32'h500);
    for (int i = 0; i < 16; i++) idle(32'(i * 4));
    br(3'd1, 32'h504, 32'h10, 1, 32'd1, 32'd1, 0);

    @(negedge clk);
    #4;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Branch resolution and prediction controller for the pipelined OTTER core.
- Consumes the EX-stage branch-condition flags (br_eq, br_lt, br_ltu) and decodes B-type func3 to resolve branches.
- Keeps a direct-mapped table of 2-bit saturating counters that supplies taken/not-taken predictions to IF.
- On a misprediction it issues a one-cycle redirect and flush, then enforces a one-cycle recovery bubble.

Parameters:
- IDX_W, 4, BHT index width; table depth = 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  32  fetch-stage PC used for prediction lookup.
- pred_taken  out  1  prediction for if_pc; combinational = bht[if_pc[IDX_W+1:2]][1].
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_stall  in  1  EX stage frozen this cycle.
- ex_opcode  in  7  EX instruction opcode.
- ex_func3  in  3  EX instruction func3.
- ex_pc  in  32  EX instruction PC.
- ex_imm  in  32  sign-extended B-type immediate.
- ex_pred_taken  in  1  prediction that travelled with the EX instruction.
- br_eq, br_lt, br_ltu  in  1 each  branch condition flags for EX rs1/rs2.
- redirect  out  1  mispredict; IF must load redirect_pc.
- redirect_pc  out  32  corrected next PC.
- flush  out  1  kill IF/ID contents; equals redirect.
- illegal_br  out  1  branch opcode with func3 010/011.
- branch_cnt  out  CNT_W  resolved branches, saturating.
- mispred_cnt  out  CNT_W  mispredictions, saturating.

Behaviour:
- is_br = ex_opcode==7'b1100011.
- act = ex_valid & ~ex_stall & is_br & (state==IDLE).
- taken by func3:
  - 000: br_eq
  - 001: ~br_eq
  - 100: br_lt
  - 101: ~br_lt
  - 110: br_ltu
  - 111: ~br_ltu
  - 010/011: taken=0, illegal_br=act; no BHT update, no count, no redirect.
- mispredict = act & legal & (taken != ex_pred_taken).
- Combinational outputs, same cycle:
  - redirect = flush = mispredict.
  - redirect_pc = taken ? ex_pc+ex_imm : ex_pc+4, mod 2**32 with no overflow flag. Valid only while redirect=1; otherwise it still reflects the formula.
- FSM, two states:
  - IDLE -> RECOVER on mispredict.
  - RECOVER -> IDLE unconditionally after one cycle, even if ex_stall=1.
  - In RECOVER, act is forced 0: the instruction in EX is the flushed wrong-path slot. No update, count, redirect or illegal_br.
- BHT update on clk edge when act & legal, at index ex_pc[IDX_W+1:2]:
  - taken: saturating increment to a max of 2'b11.
  - not taken: saturating decrement to a min of 2'b00.
- Same-index read and write in one cycle: pred_taken shows the pre-update value; there is no bypass.
- Counters:
  - branch_cnt += 1 on act & legal.
  - mispred_cnt += 1 on mispredict.
  - Both hold at all-ones.
- ex_stall=1 with a branch in EX: no effect that cycle; the branch resolves in the first unstalled cycle.
- Reset (async, any time, including in RECOVER):
  - state=IDLE.
  - All BHT entries = 2'b01 (weakly not-taken), so pred_taken=0 for every PC.
  - branch_cnt = mispred_cnt = 0.
  - Combinational outputs follow the reset state: redirect/flush/illegal_br are 0 unless inputs indicate a branch.
- Latency:
  - Resolution to redirect: 0 cycles.
  - Update visible to pred_taken: 1 cycle.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0; branch_cnt=0; mispred_cnt=0; redirect=0.
- BEQ at ex_pc=0x100, ex_imm=0x20, br_eq=1, ex_pred_taken=0 -> same cycle redirect=flush=1, redirect_pc=0x120. Next cycle RECOVER, and a valid BEQ presented then is ignored (no count). bht[0] becomes 2'b10, so if_pc=0x100 gives pred_taken=1. branch_cnt=1, mispred_cnt=1.
- Three more taken BEQs at 0x100, predicted correctly -> no redirect; counter saturates at 2'b11. Then one not-taken with pred=1 -> redirect_pc=0x104 and counter=2'b10.
- BGEU with rs1=0xFFFFFFFF, rs2=1 (br_ltu=0, br_lt=1), pred=0 -> taken and redirect. Repeat as BGE with the same flags -> not taken, no redirect.
- func3=010 branch -> illegal_br=1, redirect=0, counts unchanged. ex_stall=1 on a mispredicting BNE -> nothing. Release the stall -> redirect fires.
- Preload mispred_cnt to 0xFFFF via repeated mispredicts (or force), one more -> it holds at 0xFFFF. Assert rst mid-RECOVER -> state=IDLE, counters=0, pred_taken=0 for all PCs.
